ex_muldiv_unit: RTL and testbench

Iterative multiply/divide unit in the EX stage. It consumes the operand and control outputs of the ID/EX pipeline register and owns the architectural HI/LO registers. It executes MULT, MULTU, DIV and DIVU over 32 cycles, and MTHI/MTLO in one cycle. While busy it raises a stall request to the hazard unit, which freezes IF/ID and ID/EX.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/muldiv_core.sv | 70 +++++++
 rtl/ex_muldiv_unit.sv | 117 +++++++++++
 tb/tb_ex_muldiv_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions used by the EX-stage multiply/divide unit:
// op encodings, FSM state constants and the default datapath width.
package mips_pkg;

  localparam int MD_XLEN = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_t;

  typedef logic [1:0] md_state_t;

  localparam md_state_t IDLE = 2'd0;
  localparam md_state_t RUN  = 2'd1;
  localparam md_state_t FIN  = 2'd2;

endpackage

// File: rtl/muldiv_core.sv
// Shared shift datapath for iterative multiply (shift-add) and restoring
// divide: one bit per step, accumulator plus shift register plus counter.
module muldiv_core
  import mips_pkg::*;
#(
  parameter int XLEN = MD_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  output logic [XLEN-1:0] acc,
  output logic [XLEN-1:0] sreg,
  output logic            last
);

  localparam int CW = $clog2(XLEN);

  logic [XLEN-1:0] opnd;
  logic [CW-1:0]   counter;
  logic [XLEN:0]   add_sum;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] acc_nxt;
  logic [XLEN-1:0] sreg_nxt;

  // Multiply: {acc,sreg} holds the growing product with the multiplier
  // shifting out of sreg. Divide: sreg holds the dividend shifting into the
  // remainder (acc) while quotient bits shift in at the bottom.
  always_comb begin
    add_sum  = {1'b0, acc} + (sreg[0] ? {1'b0, opnd} : '0);
    shifted  = {acc, sreg[XLEN-1]};
    diff     = shifted - {1'b0, opnd};
    acc_nxt  = add_sum[XLEN:1];
    sreg_nxt = {add_sum[0], sreg[XLEN-1:1]};
    if (is_div) begin
      if (diff[XLEN]) begin
        acc_nxt  = shifted[XLEN-1:0];
        sreg_nxt = {sreg[XLEN-2:0], 1'b0};
      end else begin
        acc_nxt  = diff[XLEN-1:0];
        sreg_nxt = {sreg[XLEN-2:0], 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      sreg    <= '0;
      opnd    <= '0;
      counter <= '0;
    end else if (load) begin
      acc     <= '0;
      sreg    <= opa;
      opnd    <= opb;
      counter <= '0;
    end else if (step) begin
      acc     <= acc_nxt;
      sreg    <= sreg_nxt;
      counter <= counter + 1'b1;
    end
  end

  assign last = (counter == CW'(XLEN - 1));

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit: owns HI/LO, runs MULT/MULTU/DIV/DIVU
// over XLEN cycles, MTHI/MTLO in one, and requests stalls while busy.
module ex_muldiv_unit
  import mips_pkg::*;
#(
  parameter int XLEN = MD_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  input  logic            mf_req,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  md_state_t state;
  logic      is_div, rsign, remsign, dz;

  logic            start_ok, md_op, signed_op, div_op, dz_now;
  logic [XLEN-1:0] a_abs, b_abs, core_a, core_b;
  logic [XLEN-1:0] acc, sreg;
  logic            last;

  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   hi_res, lo_res;

  assign start_ok  = start & ~flush & (state == IDLE);
  assign md_op     = ~op[2];
  assign div_op    = ~op[2] & op[1];
  assign signed_op = (op == MD_MULT) | (op == MD_DIV);
  assign dz_now    = div_op & (b == '0);

  assign a_abs = a[XLEN-1] ? -a : a;
  assign b_abs = b[XLEN-1] ? -b : b;

  // A zero divisor keeps the raw dividend in sreg so FIN can return it in HI.
  assign core_a = (signed_op & ~dz_now) ? a_abs : a;
  assign core_b = signed_op ? b_abs : b;

  muldiv_core #(.XLEN(XLEN)) u_core (
    .clk    (clk),
    .reset  (reset),
    .load   (start_ok & md_op),
    .step   (state == RUN),
    .is_div (is_div),
    .opa    (core_a),
    .opb    (core_b),
    .acc    (acc),
    .sreg   (sreg),
    .last   (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      is_div  <= 1'b0;
      rsign   <= 1'b0;
      remsign <= 1'b0;
      dz      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_ok && md_op) begin
          state   <= dz_now ? FIN : RUN;
          is_div  <= div_op;
          rsign   <= signed_op & (a[XLEN-1] ^ b[XLEN-1]);
          remsign <= signed_op & a[XLEN-1];
          dz      <= dz_now;
        end
        RUN: begin
          if (flush)     state <= IDLE;
          else if (last) state <= FIN;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    prod     = {acc, sreg};
    prod_fix = rsign ? -prod : prod;
    hi_res   = prod_fix[2*XLEN-1:XLEN];
    lo_res   = prod_fix[XLEN-1:0];
    if (dz) begin
      hi_res = sreg;
      lo_res = '1;
    end else if (is_div) begin
      hi_res = remsign ? -acc : acc;
      lo_res = rsign ? -sreg : sreg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (start_ok && op == MD_MTHI) begin
      hi <= a;
    end else if (start_ok && op == MD_MTLO) begin
      lo <= a;
    end else if (state == FIN && !flush) begin
      hi <= hi_res;
      lo <= lo_res;
    end
  end

  assign busy  = (state != IDLE);
  assign stall = busy & (start | mf_req);
  assign done  = (state == FIN) & ~flush;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: a table of mul/div vectors with
// hand-computed results plus sequences for MT, flush, stall and reset cases.
module tb_ex_muldiv_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, flush, mf_req;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_lat;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .mf_req (mf_req),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // One-cycle start pulse, sampled at the next posedge (edge N).
  task automatic applyStimulus(input logic [2:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                               input logic t_flush, input logic t_mf);
    @(negedge clk);
    start  = 1'b1;
    op     = t_op;
    a      = t_a;
    b      = t_b;
    flush  = t_flush;
    mf_req = t_mf;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    int lat, busy_cnt, stall_bad;
    logic done_seen;

    vecs[0]  = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 33};
    vecs[1]  = '{3'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 33};
    vecs[2]  = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    vecs[3]  = '{3'd3, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 33};
    vecs[4]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33};
    vecs[5]  = '{3'd3, 32'h0000_0009, 32'h0000_0000, 32'h0000_0009, 32'hFFFF_FFFF, 1};
    vecs[6]  = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 33};
    vecs[7]  = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33};
    vecs[8]  = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1};
    vecs[9]  = '{3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 33};
    vecs[10] = '{3'd3, 32'hFFFF_FFFF, 32'h0000_000A, 32'h0000_0005, 32'h1999_9999, 33};
    vecs[11] = '{3'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 33};

    reset = 1'b1; start = 1'b0; flush = 1'b0; mf_req = 1'b0;
    op = 3'd0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_hi",    hi, 32'h0);
    checkOutput("reset_lo",    lo, 32'h0);
    checkOutput("reset_busy",  {31'b0, busy}, 32'h0);
    checkOutput("reset_done",  {31'b0, done}, 32'h0);
    checkOutput("reset_stall", {31'b0, stall}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b0);
      lat = 0; busy_cnt = 0;
      for (int k = 1; k <= 40 && lat == 0; k++) begin
        @(negedge clk);
        if (busy) busy_cnt++;
        if (done) lat = k;
      end
      checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      checkOutput($sformatf("v%0d_busy_cycles", i), 32'(busy_cnt), 32'(vecs[i].exp_lat));
      @(negedge clk);
      checkOutput($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
      checkOutput($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
      checkOutput($sformatf("v%0d_idle", i), {31'b0, busy}, 32'h0);
    end

    // MTHI then MFHI in the very next cycle: new value visible, no stall.
    applyStimulus(3'd4, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    mf_req = 1'b1;
    #1;
    checkOutput("mthi_hi", hi, 32'h1234_5678);
    checkOutput("mfhi_stall", {31'b0, stall}, 32'h0);
    mf_req = 1'b0;

    applyStimulus(3'd5, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0);
    applyStimulus(3'd5, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("mtlo_flush_lo", lo, 32'hCAFE_F00D);

    applyStimulus(3'd6, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("noop_busy", {31'b0, busy}, 32'h0);
    checkOutput("noop_hi", hi, 32'h1234_5678);
    checkOutput("noop_lo", lo, 32'hCAFE_F00D);

    // Flush during RUN: abort with no done pulse and HI/LO untouched.
    applyStimulus(3'd4, 32'hA5A5_A5A5, 32'h0, 1'b0, 1'b0);
    applyStimulus(3'd5, 32'hA5A5_A5A5, 32'h0, 1'b0, 1'b0);
    applyStimulus(3'd0, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b0);
    done_seen = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
      if (k == 10) flush = 1'b1;
    end
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_busy", {31'b0, busy}, 32'h0);
    for (int k = 0; k < 30; k++) begin
      if (done) done_seen = 1'b1;
      @(negedge clk);
    end
    checkOutput("flush_no_done", {31'b0, done_seen}, 32'h0);
    checkOutput("flush_hi", hi, 32'hA5A5_A5A5);
    checkOutput("flush_lo", lo, 32'hA5A5_A5A5);

    // mf_req held through DIVU 100/7, with a stray start while busy.
    applyStimulus(3'd3, 32'd100, 32'd7, 1'b0, 1'b1);
    lat = 0; busy_cnt = 0; stall_bad = 0;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (!stall) stall_bad++;
      if (done) lat = k;
      if (k == 5) begin
        start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd3;
      end
      if (k == 6) start = 1'b0;
    end
    checkOutput("mf_stall_held", 32'(stall_bad), 32'h0);
    checkOutput("mf_latency", 32'(lat), 32'd33);
    checkOutput("mf_busy_cycles", 32'(busy_cnt), 32'd33);
    @(negedge clk);
    checkOutput("mf_stall_release", {31'b0, stall}, 32'h0);
    checkOutput("mf_lo", lo, 32'd14);
    checkOutput("mf_hi", hi, 32'd2);
    mf_req = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("busy_start_ignored", {31'b0, busy}, 32'h0);
    checkOutput("busy_start_lo", lo, 32'd14);

    // Reset mid-operation clears HI/LO and returns to idle.
    applyStimulus(3'd1, 32'd5, 32'd5, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midreset_busy", {31'b0, busy}, 32'h0);
    checkOutput("midreset_hi", hi, 32'h0);
    checkOutput("midreset_lo", lo, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
